// File: rtl/mtcmos_sleep_ctrl.sv
// mtcmos_sleep_ctrl
// Sleep-sequencing controller driving the sleep pins of an MTCMOS flip-flop bank.
// A qualified sleep request is sequenced as isolate -> sleep -> rail-settle wake
// -> de-isolate. The sequence guarantees that no flip-flop sees a clock pulse or
// data change while its sleep state is in transition.
//
// Ports:
//   clk         : clock, all state changes on rising edge
//   rst_n       : asynchronous active-low reset
//   sleep_req   : level sleep request from power manager
//   wake_req    : event wake, forces exit from sleep
//   busy        : domain activity, blocks sleep entry
//   sleep       : registered drive to flip-flop sleep pins
//   iso_en      : registered output-isolation enable
//   ack         : high only while in SLEEP
//   state       : current FSM encoding
//   sleep_count : saturating count of SLEEP entries
module mtcmos_sleep_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned ISO_CYCLES  = 2,
  parameter int unsigned WAKE_CYCLES = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sleep_req,
  input  logic        wake_req,
  input  logic        busy,
  output logic        sleep,
  output logic        iso_en,
  output logic        ack,
  output logic [2:0]  state,
  output logic [15:0] sleep_count
);

  typedef enum logic [2:0] {
    ST_ACTIVE    = 3'd0,
    ST_IDLE_WAIT = 3'd1,
    ST_ISOLATE   = 3'd2,
    ST_SLEEP     = 3'd3,
    ST_WAKE      = 3'd4,
    ST_DEISO     = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ISO_LAST  = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic [15:0]        sleep_count_q, sleep_count_d;
  logic               sleep_q, sleep_d;
  logic               iso_q, iso_d;
  logic               ack_q, ack_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    armed_d       = armed_q;
    sleep_count_d = sleep_count_q;

    case (state_q)
      ST_ACTIVE: begin
        if (!sleep_req) begin
          armed_d = 1'b1;
        end else if (!busy && armed_q) begin
          state_d = ST_IDLE_WAIT;
          cnt_d   = '0;
        end
      end

      ST_IDLE_WAIT: begin
        // busy is checked before the terminal count so it wins on the last cycle
        if (busy || !sleep_req) begin
          state_d = ST_ACTIVE;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = ST_ISOLATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_ISOLATE: begin
        if (wake_req || !sleep_req) begin
          state_d = ST_DEISO;
          armed_d = 1'b0;
        end else if (cnt_q == ISO_LAST) begin
          state_d = ST_SLEEP;
          armed_d = 1'b0;
          if (sleep_count_q != '1) begin
            sleep_count_d = sleep_count_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SLEEP: begin
        if (wake_req || !sleep_req) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end

      ST_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = ST_DEISO;
          armed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DEISO: begin
        state_d = ST_ACTIVE;
      end

      default: begin
        state_d = ST_ACTIVE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies
    // change on the same edge as the state register.
    sleep_d = (state_d == ST_SLEEP);
    ack_d   = (state_d == ST_SLEEP);
    iso_d   = (state_d == ST_ISOLATE) || (state_d == ST_SLEEP) ||
              (state_d == ST_WAKE)    || (state_d == ST_DEISO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ACTIVE;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      sleep_count_q <= '0;
      sleep_q       <= 1'b0;
      iso_q         <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      sleep_count_q <= sleep_count_d;
      sleep_q       <= sleep_d;
      iso_q         <= iso_d;
      ack_q         <= ack_d;
    end
  end

  assign sleep       = sleep_q;
  assign iso_en      = iso_q;
  assign ack         = ack_q;
  assign state       = state_q;
  assign sleep_count = sleep_count_q;

endmodule

// File: tb/tb_mtcmos_sleep_ctrl.sv
// tb_mtcmos_sleep_ctrl
// Directed bench for mtcmos_sleep_ctrl with IDLE=4, ISO=2, WAKE=3.
// Expected output tuples are queued as each stimulus step is driven, then popped
// and compared once the DUT has clocked that step.
module tb_mtcmos_sleep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        sleep_req;
  logic        wake_req;
  logic        busy;
  logic        sleep;
  logic        iso_en;
  logic        ack;
  logic [2:0]  state;
  logic [15:0] sleep_count;

  int unsigned total;
  int unsigned bad;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic        sl;
    logic        iso;
    logic        ak;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq[$];

  mtcmos_sleep_ctrl #(
    .IDLE_CYCLES(4),
    .ISO_CYCLES (2),
    .WAKE_CYCLES(3),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sleep_req  (sleep_req),
    .wake_req   (wake_req),
    .busy       (busy),
    .sleep      (sleep),
    .iso_en     (iso_en),
    .ack        (ack),
    .state      (state),
    .sleep_count(sleep_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [2:0] st, input logic sl,
                      input logic iso, input logic ak, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.st = st; e.sl = sl; e.iso = iso; e.ak = ak; e.cnt = cnt;
    sbq.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    logic [21:0] obs, want;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e    = sbq.pop_front();
      obs  = {state, sleep, iso_en, ack, sleep_count};
      want = {e.st, e.sl, e.iso, e.ak, e.cnt};
      assert (obs === want) else begin
        bad++;
        $error("FAIL %s: got st=%0d sleep=%b iso=%b ack=%b cnt=%h, want st=%0d sleep=%b iso=%b ack=%b cnt=%h",
               e.tag, state, sleep, iso_en, ack, sleep_count, e.st, e.sl, e.iso, e.ak, e.cnt);
      end
    end
  endtask

  // Queue expectation, let one rising edge happen, compare at the falling edge.
  task automatic step(input string tag, input logic [2:0] st, input logic sl,
                      input logic iso, input logic ak, input logic [15:0] cnt);
    push(tag, st, sl, iso, ak, cnt);
    @(negedge clk);
    pop_chk();
  endtask

  // From ACTIVE: arm for one cycle, request, and walk through to SLEEP.
  task automatic enter(input logic [15:0] cprev, input logic [15:0] cnew);
    sleep_req = 1'b0;
    step("arm", 3'd0, 1'b0, 1'b0, 1'b0, cprev);
    sleep_req = 1'b1;
    step("idle_e0", 3'd1, 1'b0, 1'b0, 1'b0, cprev);
    step("idle_e1", 3'd1, 1'b0, 1'b0, 1'b0, cprev);
    step("idle_e2", 3'd1, 1'b0, 1'b0, 1'b0, cprev);
    step("idle_e3", 3'd1, 1'b0, 1'b0, 1'b0, cprev);
    step("iso_e4",  3'd2, 1'b0, 1'b1, 1'b0, cprev);
    step("iso_e5",  3'd2, 1'b0, 1'b1, 1'b0, cprev);
    step("sleep_e6", 3'd3, 1'b1, 1'b1, 1'b1, cnew);
  endtask

  // From SLEEP: drop the request and walk through WAKE/DEISO back to ACTIVE.
  task automatic exit_req(input logic [15:0] c);
    sleep_req = 1'b0;
    step("wake_k",  3'd4, 1'b0, 1'b1, 1'b0, c);
    step("wake_k1", 3'd4, 1'b0, 1'b1, 1'b0, c);
    step("wake_k2", 3'd4, 1'b0, 1'b1, 1'b0, c);
    step("deiso_k3", 3'd5, 1'b0, 1'b1, 1'b0, c);
    step("active_k4", 3'd0, 1'b0, 1'b0, 1'b0, c);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    sleep_req = 1'b0;
    wake_req  = 1'b0;
    busy      = 1'b0;
    repeat (2) @(negedge clk);
    push("reset_state", 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    pop_chk();
    rst_n = 1'b1;
    @(negedge clk);

    // Entry/exit timing
    enter(16'd0, 16'd1);
    exit_req(16'd1);

    // Busy abort in the 3rd IDLE_WAIT cycle, then full restart of the idle count
    step("rearm", 3'd0, 1'b0, 1'b0, 1'b0, 16'd1);
    sleep_req = 1'b1;
    step("b_idle1", 3'd1, 1'b0, 1'b0, 1'b0, 16'd1);
    step("b_idle2", 3'd1, 1'b0, 1'b0, 1'b0, 16'd1);
    step("b_idle3", 3'd1, 1'b0, 1'b0, 1'b0, 16'd1);
    busy = 1'b1;
    step("busy_abort", 3'd0, 1'b0, 1'b0, 1'b0, 16'd1);
    busy = 1'b0;
    step("r_idle0", 3'd1, 1'b0, 1'b0, 1'b0, 16'd1);
    step("r_idle1", 3'd1, 1'b0, 1'b0, 1'b0, 16'd1);
    step("r_idle2", 3'd1, 1'b0, 1'b0, 1'b0, 16'd1);
    step("r_idle3", 3'd1, 1'b0, 1'b0, 1'b0, 16'd1);
    step("r_iso",   3'd2, 1'b0, 1'b1, 1'b0, 16'd1);

    // Isolate abort via wake_req: 2 -> 5 -> 0, sleep never rises
    wake_req = 1'b1;
    step("iabort_deiso", 3'd5, 1'b0, 1'b1, 1'b0, 16'd1);
    wake_req = 1'b0;
    step("iabort_active", 3'd0, 1'b0, 1'b0, 1'b0, 16'd1);
    step("iabort_hold", 3'd0, 1'b0, 1'b0, 1'b0, 16'd1);

    // Re-arm rule: exit by wake_req with sleep_req still high
    enter(16'd1, 16'd2);
    wake_req = 1'b1;
    step("w_wake0", 3'd4, 1'b0, 1'b1, 1'b0, 16'd2);
    wake_req = 1'b0;
    step("w_wake1", 3'd4, 1'b0, 1'b1, 1'b0, 16'd2);
    step("w_wake2", 3'd4, 1'b0, 1'b1, 1'b0, 16'd2);
    step("w_deiso", 3'd5, 1'b0, 1'b1, 1'b0, 16'd2);
    for (int i = 0; i < 10; i++) begin
      step("noarm_hold", 3'd0, 1'b0, 1'b0, 1'b0, 16'd2);
    end
    enter(16'd2, 16'd3);

    // Asynchronous reset in SLEEP, checked before the next rising edge
    #2 rst_n = 1'b0;
    #1;
    push("async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    pop_chk();
    sleep_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Saturation from 0xFFFE
    force dut.sleep_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.sleep_count_q;
    step("preload", 3'd0, 1'b0, 1'b0, 1'b0, 16'hFFFE);
    enter(16'hFFFE, 16'hFFFF);
    exit_req(16'hFFFF);
    enter(16'hFFFF, 16'hFFFF);
    exit_req(16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtcmos_sleep_ctrl.md
# mtcmos_sleep_ctrl

Sleep-sequencing controller that drives the `sleep` input of the MTCMOS low-power flip-flop bank, i.e. the initiator side of the sleep interface that the flip-flops respond to. It accepts a sleep request from the power manager and qualifies it against domain activity. It then sequences isolation → sleep assertion → rail-settle wake → de-isolation, so that no flip-flop sees a clock pulse or data change while its sleep state is in transition. It also acknowledges the requester and counts completed sleep entries.

## Interface
- `IDLE_CYCLES`, 16: consecutive idle, requested cycles required before isolation (≥1).
- `ISO_CYCLES`, 2: cycles `iso_en` is held before `sleep` asserts (≥1).
- `WAKE_CYCLES`, 8: rail-settle cycles after `sleep` drops, before de-isolation (≥1).
- `CNT_W`, 8: phase-counter width; must hold max(IDLE_CYCLES, ISO_CYCLES, WAKE_CYCLES) − 1.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `sleep_req`, input, 1: level request from the power manager; high = enter sleep, low = leave or stay awake.
- `wake_req`, input, 1: event wake; forces exit from sleep regardless of `sleep_req`.
- `busy`, input, 1: domain activity; high blocks sleep entry.
- `sleep`, output, 1: registered drive to the flip-flop `sleep` pins.
- `iso_en`, output, 1: registered output-isolation enable.
- `ack`, output, 1: high only while in SLEEP.
- `state`, output, 3: current FSM encoding.
- `sleep_count`, output, 16: number of SLEEP entries; saturates at 0xFFFF.

## Operation
- **States** (encoding): ACTIVE=0, IDLE_WAIT=1, ISOLATE=2, SLEEP=3, WAKE=4, DEISO=5. Codes 6 and 7 return to ACTIVE on the next edge.
- **Outputs by state**, all registered from the state:
  - ACTIVE and IDLE_WAIT: `sleep`=0, `iso_en`=0, `ack`=0.
  - ISOLATE: `iso_en`=1.
  - SLEEP: `sleep`=1, `iso_en`=1, `ack`=1.
  - WAKE and DEISO: `sleep`=0, `iso_en`=1, `ack`=0.
- **Re-arm flag `armed`:**
  - Set whenever `sleep_req`=0 is sampled in ACTIVE.
  - Cleared on entering SLEEP or DEISO.
  - Sleep entry requires `armed`=1. A requester must therefore drop `sleep_req` at least one cycle before each new request; this prevents re-sleep straight after a `wake_req` exit.
- **Transitions:**
  - ACTIVE → IDLE_WAIT when `sleep_req` & !`busy` & `armed`; clear the counter.
  - IDLE_WAIT: if `busy` or !`sleep_req` → ACTIVE. Otherwise, when the counter == IDLE_CYCLES−1 → ISOLATE with the counter cleared; else counter +1.
  - ISOLATE: if `wake_req` or !`sleep_req` → DEISO (abort; `sleep` never asserts). Else, when the counter == ISO_CYCLES−1 → SLEEP; else counter +1. `busy` is ignored here.
  - SLEEP: `wake_req` or !`sleep_req` → WAKE with the counter cleared. On entry, `sleep_count` +1 (saturating).
  - WAKE: when the counter == WAKE_CYCLES−1 → DEISO; else counter +1. All inputs are ignored.
  - DEISO: one cycle, then → ACTIVE. Inputs are ignored.
- **Reset:** state=ACTIVE, counter=0, `armed`=0, `sleep_count`=0, `sleep`=0, `iso_en`=0, `ack`=0.
  - Reset asserted mid-sequence, including in SLEEP, drops `sleep` and `iso_en` immediately (asynchronously).

## Timing
- Let edge E0 be the edge that samples the qualifying request in ACTIVE. Then:
  - IDLE_WAIT is entered after E0.
  - ISOLATE is entered after E0+IDLE_CYCLES; `iso_en` rises then.
  - SLEEP is entered after E0+IDLE_CYCLES+ISO_CYCLES; `sleep` and `ack` rise then.
- `iso_en` always leads `sleep` by exactly ISO_CYCLES cycles on entry.
- Let edge K be the edge that samples the exit condition in SLEEP. Then:
  - `sleep` and `ack` fall after K.
  - DEISO is entered after K+WAKE_CYCLES.
  - ACTIVE is entered and `iso_en` falls after K+WAKE_CYCLES+1.
- `sleep` and `iso_en` never change on the same edge.
- `wake_req` and `sleep_req` falling on the same edge are treated as a single exit.
- `busy` rising on the same edge IDLE_WAIT would complete → ACTIVE; `busy` wins.

## Test plan
- **Entry/exit timing.** IDLE=4, ISO=2, WAKE=3; `armed` via `sleep_req`=0 for one cycle; then `sleep_req`=1, `busy`=0 sampled at E0.
  - Required: `iso_en`=1 after E0+4; `sleep`=`ack`=1 after E0+6; `sleep_count`=1.
  - Then `sleep_req`=0 at K. Required: `sleep`=0 after K; `iso_en`=0 after K+4.
- **Busy abort.** `busy` pulses high in the 3rd IDLE_WAIT cycle.
  - Required: state=0 next cycle; `iso_en` never rises.
  - Then, after `busy` drops, the full IDLE count restarts from 0.
- **Isolate abort.** `wake_req`=1 during ISOLATE.
  - Required: state 2→5→0; `sleep` stays 0; `sleep_count` unchanged.
- **Re-arm rule.** Exit via `wake_req` while `sleep_req` is held 1.
  - Required: controller stays in ACTIVE indefinitely.
  - Dropping `sleep_req` for one cycle and raising it again gives a new entry.
- **Async reset in SLEEP.** Assert `rst_n`=0 mid-cycle.
  - Required: `sleep`=`iso_en`=`ack`=0 before the next `clk` edge; `state`=0; `sleep_count`=0.
- **Saturation.** Preload via 65535 entries, or force the counter to 0xFFFE.
  - Required: two further entries leave `sleep_count`=0xFFFF.
